// File: rtl/sparse_pkg.sv
// Shared parameters, lane types and the packed output-vector record for sparse_index_packer.
package sparse_pkg;

  localparam int VEC_LEN   = 4;
  localparam int MAX_INDEX = 15;
  localparam int IDX_W     = $clog2(MAX_INDEX);
  localparam int DATA_W    = 8;
  localparam int ROWS      = 16;
  localparam int COLS      = 16;
  localparam int CNT_W     = $clog2(VEC_LEN);
  localparam int POS_W     = $clog2(ROWS * COLS) + 2;

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [DATA_W-1:0] val_t;

  typedef struct packed {
    idx_t [VEC_LEN-1:0] index;
    val_t [VEC_LEN-1:0] value;
    logic [VEC_LEN-1:0] mask;
    logic               last;
  } sparse_vec_t;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/sparse_index_packer_if.sv
// Entry-stream input, lane-vector output and overflow status of sparse_index_packer.
interface sparse_index_packer_if;
  import sparse_pkg::*;

  logic               in_valid;
  logic               in_ready;
  idx_t               in_index;
  val_t               in_value;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  idx_t [VEC_LEN-1:0] out_index;
  val_t [VEC_LEN-1:0] out_value;
  logic [VEC_LEN-1:0] out_mask;
  logic               out_last;
  logic               err_overflow;

  modport master (
    output in_valid, in_index, in_value, in_last, out_ready,
    input  in_ready, out_valid, out_index, out_value, out_mask, out_last, err_overflow
  );

  modport slave (
    input  in_valid, in_index, in_value, in_last, out_ready,
    output in_ready, out_valid, out_index, out_value, out_mask, out_last, err_overflow
  );

endinterface

// File: rtl/sparse_pos_checker.sv
// Running tile-position tracker; raises a sticky flag once a tile runs past ROWS*COLS.
module sparse_pos_checker
  import sparse_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic beat_i,
  input  idx_t index_i,
  input  logic last_i,
  output logic err_o
);

  logic [POS_W-1:0] pos_q, pos_d, pos_upd;
  logic             err_q, err_d;

  always_comb begin
    pos_upd = pos_q + POS_W'(index_i) + POS_W'(1);
    pos_d   = pos_q;
    err_d   = err_q;
    if (beat_i) begin
      pos_d = last_i ? '0 : pos_upd;
      if (pos_upd > POS_W'(ROWS * COLS)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q <= '0;
      err_q <= 1'b0;
    end else begin
      pos_q <= pos_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/sparse_index_packer.sv
// Packs (zero-run index, value) entries into VEC_LEN-lane vectors with mask and tile-last.
// Optional bound check: define SPARSE_PACK_BOUND_CHECK_EN to enable err_overflow.
module sparse_index_packer
  import sparse_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  sparse_index_packer_if.slave  bus_if
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  sparse_vec_t         asm_q, asm_d;
  sparse_vec_t         out_q, out_d;
  logic                out_vld_q, out_vld_d;
  sparse_vec_t         merged;
  logic                accept, complete, out_free;

  assign bus_if.in_ready = (state_q == FILL);
  assign accept   = bus_if.in_valid && (state_q == FILL);
  assign complete = (cnt_q == CNT_W'(VEC_LEN - 1)) || bus_if.in_last;
  assign out_free = !out_vld_q || bus_if.out_ready;

  // Lanes above the incoming one are forced to zero, so stale assembly data never leaks as padding.
  always_comb begin
    merged = '0;
    for (int i = 0; i < VEC_LEN; i++) begin
      if (i < int'(cnt_q)) begin
        merged.index[i] = asm_q.index[i];
        merged.value[i] = asm_q.value[i];
        merged.mask[i]  = 1'b1;
      end else if (i == int'(cnt_q)) begin
        merged.index[i] = bus_if.in_index;
        merged.value[i] = bus_if.in_value;
        merged.mask[i]  = 1'b1;
      end
    end
    merged.last = bus_if.in_last;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    out_d     = out_q;
    out_vld_d = out_vld_q && !bus_if.out_ready;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          asm_d = merged;
          if (!complete) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else if (out_free) begin
            out_d     = merged;
            out_vld_d = 1'b1;
            cnt_d     = '0;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_free) begin
          out_d     = asm_q;
          out_vld_d = 1'b1;
          cnt_d     = '0;
          state_d   = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    asm_q <= asm_d;
  end

  assign bus_if.out_valid = out_vld_q;
  assign bus_if.out_index = out_q.index;
  assign bus_if.out_value = out_q.value;
  assign bus_if.out_mask  = out_q.mask;
  assign bus_if.out_last  = out_q.last;

`ifdef SPARSE_PACK_BOUND_CHECK_EN
  logic err_w;

  sparse_pos_checker u_pos_checker (
    .clk     (clk),
    .rst     (rst),
    .beat_i  (accept),
    .index_i (bus_if.in_index),
    .last_i  (bus_if.in_last),
    .err_o   (err_w)
  );

  assign bus_if.err_overflow = err_w;
`else
  assign bus_if.err_overflow = 1'b0;
`endif

endmodule
